// File: rtl/prim_pad_bank_filter_if.sv
// Core-side bundle of the pad bank: drive controls toward the pads, filtered samples back.
// Latency: none, this is a signal bundle only.
// Backpressure: none; every signal is a level valid on every cycle.
// The rise/fall pulse signals exist only when PAD_EDGE_DETECT_EN is defined.
interface prim_pad_bank_filter_if #(
    parameter int NumPads = 4,
    parameter int AttrDw  = 2
);
    logic [NumPads-1:0]        out_dat;
    logic [NumPads-1:0]        oe;
    logic [NumPads*AttrDw-1:0] attr;
    logic [NumPads-1:0]        filt_en;
    logic [NumPads-1:0]        in_raw;
    logic [NumPads-1:0]        in_dat;
`ifdef PAD_EDGE_DETECT_EN
    logic [NumPads-1:0]        rise;
    logic [NumPads-1:0]        fall;
`endif

    modport master (
        output out_dat, oe, attr, filt_en,
        input  in_raw, in_dat
`ifdef PAD_EDGE_DETECT_EN
        , input rise, fall
`endif
    );

    modport slave (
        input  out_dat, oe, attr, filt_en,
        output in_raw, in_dat
`ifdef PAD_EDGE_DETECT_EN
        , output rise, fall
`endif
    );
endinterface

// File: rtl/prim_pad_bank_filter.sv
// Pad bank: per-pad inversion/open-drain drive, 2-flop synchroniser, optional glitch filter.
// Latency: drive combinational; pad->in_raw 2 cycles, pad->in_dat 3 (bypass) or 2+FiltCycles.
// Backpressure: none; pads are sampled every cycle. PAD_EDGE_DETECT_EN adds rise/fall pulses.
module prim_pad_bank_filter #(
    parameter int NumPads    = 4,
    parameter int AttrDw     = 2,
    parameter int FiltCycles = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    inout  wire  [NumPads-1:0] inout_io,
    prim_pad_bank_filter_if.slave bus
);
    localparam int CntW = $clog2(FiltCycles + 1);

    logic [NumPads-1:0] inv;
    logic [NumPads-1:0] od;
    logic [NumPads-1:0] drv_out;
    logic [NumPads-1:0] drv_oe;
    logic [NumPads-1:0] raw;
    logic [NumPads-1:0] sync1;
    logic [NumPads-1:0] sync2;
    logic [NumPads-1:0] filt;
    logic [CntW-1:0]    cnt [NumPads];

    // Attribute decode and pad drive; open-drain only ever drives a 0.
    for (genvar p = 0; p < NumPads; p++) begin : g_pad
        assign inv[p]      = bus.attr[p*AttrDw];
        assign od[p]       = bus.attr[p*AttrDw + 1];
        assign drv_out[p]  = bus.out_dat[p] ^ inv[p];
        assign drv_oe[p]   = bus.oe[p] & (~od[p] | ~drv_out[p]);
        assign inout_io[p] = drv_oe[p] ? drv_out[p] : 1'bz;
    end

    // Inversion is applied before synchronising, so an inv change looks like a pad edge.
    assign raw        = inout_io ^ inv;
    assign bus.in_raw = sync2;
    assign bus.in_dat = filt;

    // Synchroniser and per-pad hold-time filter; any agreeing cycle restarts the count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int p = 0; p < NumPads; p++) begin
                cnt[p] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int p = 0; p < NumPads; p++) begin
                if (!bus.filt_en[p]) begin
                    filt[p] <= sync2[p];
                    cnt[p]  <= '0;
                end else if (sync2[p] == filt[p]) begin
                    cnt[p]  <= '0;
                end else if (cnt[p] == CntW'(FiltCycles - 1)) begin
                    filt[p] <= sync2[p];
                    cnt[p]  <= '0;
                end else begin
                    cnt[p]  <= cnt[p] + CntW'(1);
                end
            end
        end
    end

`ifdef PAD_EDGE_DETECT_EN
    logic [NumPads-1:0] filt_prev;
    logic [NumPads-1:0] rise_q;
    logic [NumPads-1:0] fall_q;

    // Registered edge pulses one cycle after in_dat changes; none at reset release.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            filt_prev <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            filt_prev <= filt;
            rise_q    <= filt & ~filt_prev;
            fall_q    <= ~filt & filt_prev;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`endif
endmodule

// File: tb/tb_prim_pad_bank_filter.sv
// Directed bench for the pad bank: reset, glitch filter, drive, bypass, reset mid-count, edges.
module tb_prim_pad_bank_filter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tb_en = 4'h0;
    logic [3:0] tb_val = 4'h0;
    wire  [3:0] pad;
    int         n_checks = 0;
    int         n_fail = 0;

    prim_pad_bank_filter_if #(.NumPads(4), .AttrDw(2)) bus_if ();

    prim_pad_bank_filter #(.NumPads(4), .AttrDw(2), .FiltCycles(4)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .inout_io (pad),
        .bus      (bus_if)
    );

    for (genvar p = 0; p < 4; p++) begin : g_tb_drv
        assign pad[p] = tb_en[p] ? tb_val[p] : 1'bz;
    end

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tb_en = 4'hF;
        tb_val = 4'hF;
        bus_if.filt_en = 4'hF;
        tick(3);
        n_checks++;
        if (bus_if.in_dat !== 4'h0) begin
            n_fail++; $display("FAIL reset_in got=%h exp=0", bus_if.in_dat);
        end
        n_checks++;
        if (bus_if.in_raw !== 4'h0) begin
            n_fail++; $display("FAIL reset_raw got=%h exp=0", bus_if.in_raw);
        end
`ifdef PAD_EDGE_DETECT_EN
        n_checks++;
        if ((bus_if.rise | bus_if.fall) !== 4'h0) begin
            n_fail++; $display("FAIL reset_edges rise=%h fall=%h exp=0", bus_if.rise, bus_if.fall);
        end
`endif
        rst_n = 1'b1;
        tick(1);
        n_checks++;
        if (bus_if.in_raw !== 4'h0) begin
            n_fail++; $display("FAIL raw_plus1 got=%h exp=0", bus_if.in_raw);
        end
        tick(1);
        n_checks++;
        if (bus_if.in_raw !== 4'hF) begin
            n_fail++; $display("FAIL raw_plus2 got=%h exp=f", bus_if.in_raw);
        end
        tick(3);
        n_checks++;
        if (bus_if.in_dat !== 4'h0) begin
            n_fail++; $display("FAIL in_plus5 got=%h exp=0", bus_if.in_dat);
        end
        tick(1);
        n_checks++;
        if (bus_if.in_dat !== 4'hF) begin
            n_fail++; $display("FAIL in_plus6 got=%h exp=f", bus_if.in_dat);
        end
`ifdef PAD_EDGE_DETECT_EN
        tick(1);
        n_checks++;
        if (bus_if.rise !== 4'hF) begin
            n_fail++; $display("FAIL reset_rise got=%h exp=f", bus_if.rise);
        end
`endif
    endtask

    task automatic test_glitch;
        tb_val = 4'h0;
        tick(10);
        n_checks++;
        if (bus_if.in_dat !== 4'h0) begin
            n_fail++; $display("FAIL settle_low got=%h exp=0", bus_if.in_dat);
        end
        tb_val = 4'b0001;
        tick(3);
        tb_val = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            n_checks++;
            if (bus_if.in_dat !== 4'h0) begin
                n_fail++; $display("FAIL glitch3 cyc=%0d got=%h exp=0", i, bus_if.in_dat);
            end
        end
        tb_val = 4'b0001;
        tick(4);
        tb_val = 4'b0000;
        tick(1);
        n_checks++;
        if (bus_if.in_dat !== 4'h0) begin
            n_fail++; $display("FAIL pulse4_early got=%h exp=0", bus_if.in_dat);
        end
        tick(1);
        n_checks++;
        if (bus_if.in_dat !== 4'b0001) begin
            n_fail++; $display("FAIL pulse4_pass got=%h exp=1", bus_if.in_dat);
        end
        tick(10);
    endtask

    task automatic test_drive;
        tb_en = 4'h0;
        bus_if.oe = 4'hF;
        bus_if.attr = {2'b11, 2'b10, 2'b10, 2'b00};
        bus_if.out_dat = 4'b0011;
        #1;
        n_checks++;
        if (pad[0] !== 1'b1) begin
            n_fail++; $display("FAIL drive_push got=%b exp=1", pad[0]);
        end
        n_checks++;
        if (pad[2] !== 1'b0) begin
            n_fail++; $display("FAIL drive_od_low got=%b exp=0", pad[2]);
        end
        n_checks++;
        if (dut.drv_oe !== 4'b0101) begin
            n_fail++; $display("FAIL drive_oe got=%b exp=0101", dut.drv_oe);
        end
        bus_if.attr = 8'b00_00_00_01;
        bus_if.out_dat = 4'b0001;
        bus_if.oe = 4'b0001;
        #1;
        n_checks++;
        if (pad[0] !== 1'b0 || dut.drv_oe !== 4'b0001) begin
            n_fail++; $display("FAIL drive_inv got=%b oe=%b exp=0 oe=0001", pad[0], dut.drv_oe);
        end
        bus_if.oe = 4'h0;
        #1;
        n_checks++;
        if (dut.drv_oe !== 4'b0000) begin
            n_fail++; $display("FAIL drive_off got=%b exp=0000", dut.drv_oe);
        end
        bus_if.attr = '0;
        bus_if.out_dat = '0;
        tb_val = 4'h0;
        tb_en = 4'hF;
        tick(12);
    endtask

    task automatic test_bypass;
        logic v;
        bus_if.filt_en = 4'b1101;
        tick(2);
        for (int k = 0; k < 4; k++) begin
            v = (k % 2 == 0);
            tb_val[1] = v;
            tick(2);
            n_checks++;
            if (bus_if.in_dat[1] !== !v) begin
                n_fail++; $display("FAIL bypass_lag2 k=%0d got=%b exp=%b", k, bus_if.in_dat[1], !v);
            end
            tick(1);
            n_checks++;
            if (bus_if.in_dat[1] !== v) begin
                n_fail++; $display("FAIL bypass_lag3 k=%0d got=%b exp=%b", k, bus_if.in_dat[1], v);
            end
            tick(2);
        end
        tb_val[1] = 1'b1;
        tick(4);
        bus_if.filt_en = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_checks++;
            if (bus_if.in_dat !== 4'b0010) begin
                n_fail++; $display("FAIL reenable cyc=%0d got=%h exp=2", i, bus_if.in_dat);
            end
        end
        tb_val[1] = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid;
        tb_val = 4'b0100;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_checks++;
        if (bus_if.in_dat !== 4'h0 || bus_if.in_raw !== 4'h0) begin
            n_fail++; $display("FAIL midrst_clear in=%h raw=%h exp=0", bus_if.in_dat, bus_if.in_raw);
        end
        tick(5);
        n_checks++;
        if (bus_if.in_dat !== 4'h0) begin
            n_fail++; $display("FAIL midrst_early got=%h exp=0", bus_if.in_dat);
        end
        tick(1);
        n_checks++;
        if (bus_if.in_dat !== 4'b0100) begin
            n_fail++; $display("FAIL midrst_full got=%h exp=4", bus_if.in_dat);
        end
        tb_val = 4'h0;
        tick(10);
    endtask

`ifdef PAD_EDGE_DETECT_EN
    task automatic test_edges;
        tb_val = 4'b1000;
        tick(6);
        n_checks++;
        if (bus_if.in_dat !== 4'b1000 || bus_if.rise !== 4'h0) begin
            n_fail++; $display("FAIL rise_pre in=%h rise=%h exp=8/0", bus_if.in_dat, bus_if.rise);
        end
        tick(1);
        n_checks++;
        if (bus_if.rise !== 4'b1000 || bus_if.fall !== 4'h0) begin
            n_fail++; $display("FAIL rise_pulse rise=%h fall=%h exp=8/0", bus_if.rise, bus_if.fall);
        end
        tick(1);
        n_checks++;
        if (bus_if.rise !== 4'h0) begin
            n_fail++; $display("FAIL rise_end got=%h exp=0", bus_if.rise);
        end
        tb_val = 4'h0;
        tick(6);
        n_checks++;
        if (bus_if.in_dat !== 4'h0 || bus_if.fall !== 4'h0) begin
            n_fail++; $display("FAIL fall_pre in=%h fall=%h exp=0/0", bus_if.in_dat, bus_if.fall);
        end
        tick(1);
        n_checks++;
        if (bus_if.fall !== 4'b1000 || bus_if.rise !== 4'h0) begin
            n_fail++; $display("FAIL fall_pulse fall=%h rise=%h exp=8/0", bus_if.fall, bus_if.rise);
        end
        tick(1);
        n_checks++;
        if (bus_if.fall !== 4'h0) begin
            n_fail++; $display("FAIL fall_end got=%h exp=0", bus_if.fall);
        end
    endtask
`endif

    initial begin
        bus_if.out_dat = '0;
        bus_if.oe = '0;
        bus_if.attr = '0;
        bus_if.filt_en = '0;
        test_reset();
        test_glitch();
        test_drive();
        test_bypass();
        test_reset_mid();
`ifdef PAD_EDGE_DETECT_EN
        test_edges();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
